// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: types shared by the memory arbiter and its link register.
//   word_t       32-bit datapath word
//   ramstate_t   status reported by the shared RAM port
//   arb_state_t  arbiter FSM state encoding
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2,
    SCFAIL = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_link_reg.sv
// arb_link_reg: LL/SC link register (link_valid + link_addr).
// Ports:
//   clk, rst_n          clock, async active-low reset (link invalid on reset)
//   set, set_addr       completed LL: arm link on set_addr
//   clear               completed SC or conflicting store: drop link
//   link_valid          link currently armed
//   link_addr           address captured by the last LL
module arb_link_reg
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  set,
  input  word_t set_addr,
  input  logic  clear,
  output logic  link_valid,
  output word_t link_addr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (set) begin
      link_valid <= 1'b1;
      link_addr  <= set_addr;
    end else if (clear) begin
      link_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and data memory.
// Data wins by default; a streak counter caps consecutive data grants while a
// fetch waits. Optional LL/SC support is built when the LLSC_EN macro is defined.
// Ports:
//   CLK, nRST                      clock, async active-low reset
//   iREN, iaddr / iload, iwait     instruction request and response
//   dREN, dWEN, daddr, dstore,
//   datomic / dload, dwait         data request (LL/SC when atomic) and response
//   ramREN, ramWEN, ramaddr,
//   ramstore / ramload, ramstate   shared RAM port
//
// state  | meaning
// IDLE   | no grant; arbitrate pending requests
// IGRANT | RAM driven by instruction fetch
// DGRANT | RAM driven by data request
// SCFAIL | failed SC: report dload=0 without touching the RAM
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int DSTREAK_MAX = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      iwait,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  input  logic      datomic,
  output word_t     dload,
  output logic      dwait,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  localparam int SW = $clog2(DSTREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DSTREAK_MAX);

  arb_state_t    state, state_next;
  logic [SW-1:0] streak;
  logic          dreq, i_done, d_done, sc_fail;

  assign dreq = dREN | dWEN;

`ifdef LLSC_EN
  logic  link_valid, ll_done, link_clear;
  word_t link_addr;

  // An SC that completes always clears the link; a plain store only when it
  // hits the linked address.
  assign ll_done    = d_done & dREN & datomic;
  assign link_clear = d_done & dWEN & (datomic | (daddr == link_addr));
  assign sc_fail    = datomic & dWEN & ~(link_valid & (daddr == link_addr));

  arb_link_reg u_link (
    .clk        (CLK),
    .rst_n      (nRST),
    .set        (ll_done),
    .set_addr   (daddr),
    .clear      (link_clear),
    .link_valid (link_valid),
    .link_addr  (link_addr)
  );
`else
  logic unused_datomic;
  assign unused_datomic = datomic;
  assign sc_fail        = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                 streak <= '0;
    else if (!iREN || i_done)                  streak <= '0;
    else if (d_done && streak != STREAK_MAX)   streak <= streak + 1'b1;
  end

  always_comb begin
    state_next = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iload      = '0;
    dload      = '0;
    iwait      = iREN;
    dwait      = dreq;
    i_done     = 1'b0;
    d_done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (dreq && (streak < STREAK_MAX || !iREN))
          state_next = sc_fail ? SCFAIL : DGRANT;
        else if (iREN)
          state_next = IGRANT;
      end
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        // A dropped request or a RAM error returns to IDLE with wait still high.
        if (!iREN || ramstate == ERROR) begin
          state_next = IDLE;
        end else if (ramstate == ACCESS) begin
          i_done     = 1'b1;
          iload      = ramload;
          iwait      = 1'b0;
          state_next = IDLE;
        end
      end
      DGRANT: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dreq || ramstate == ERROR) begin
          state_next = IDLE;
        end else if (ramstate == ACCESS) begin
          d_done     = 1'b1;
          dload      = ramload;
`ifdef LLSC_EN
          if (datomic && dWEN) dload = 32'd1;
`endif
          dwait      = 1'b0;
          state_next = IDLE;
        end
      end
      SCFAIL: begin
        dwait      = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int DMAX = 2;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN, datomic;
  word_t     iaddr, daddr, dstore;
  word_t     iload, dload, ramaddr, ramstore, ramload;
  logic      iwait, dwait, ramREN, ramWEN;
  ramstate_t ramstate;

  typedef struct packed {logic is_data; word_t val;} exp_t;
  exp_t sb[$];

  int    n_checks = 0;
  int    n_fail   = 0;
  int    lat      = 0;
  bit    force_err = 1'b0;
  int    busy_cnt = 0;
  word_t wr_data [256];
  bit    wr_valid[256];

  always #5 CLK = ~CLK;

  mem_arbiter #(.DSTREAK_MAX(DMAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .datomic(datomic),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  // RAM model: 'lat' BUSY cycles then ACCESS; word index = addr[9:2]
  function automatic word_t model_rd(input word_t a);
    logic [7:0] i;
    i = a[9:2];
    if (wr_valid[i]) return wr_data[i];
    if (i == 8'd16)  return 32'h2108000A;
    return {24'hA00000, i};
  endfunction

  always_comb begin
    ramload = model_rd(ramaddr);
    if (!(ramREN | ramWEN))  ramstate = FREE;
    else if (force_err)      ramstate = ERROR;
    else if (busy_cnt >= lat) ramstate = ACCESS;
    else                     ramstate = BUSY;
  end

  always @(posedge CLK) begin
    busy_cnt <= (ramstate == BUSY) ? busy_cnt + 1 : 0;
    if (ramWEN && ramstate == ACCESS) begin
      wr_data[ramaddr[9:2]]  <= ramstore;
      wr_valid[ramaddr[9:2]] <= 1'b1;
    end
  end

  task automatic data_xact(input bit we, input bit atomic, input word_t addr, input word_t store,
                           output bit done, output word_t got, output bit wrote, output int cycles);
    done = 0; wrote = 0; got = '0; cycles = 0;
    @(negedge CLK);
    dREN = !we; dWEN = we; datomic = atomic; daddr = addr; dstore = store;
    for (int c = 1; c <= 30 && !done; c++) begin
      #1;
      if (ramWEN) wrote = 1;
      if (!dwait) begin done = 1; got = dload; cycles = c; end
      else @(negedge CLK);
    end
    @(negedge CLK);
    dREN = 0; dWEN = 0; datomic = 0;
  endtask

  task automatic test_reset();
    nRST = 0; iREN = 1; dREN = 0; dWEN = 1; datomic = 0;
    iaddr = 32'h44; daddr = 32'h80; dstore = 32'hFFFF_FFFF;
    #2;
    n_checks++;
    if ({ramREN, ramWEN, ramaddr, ramstore, iload, dload, iwait, dwait} !==
        {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs got ren=%b wen=%b addr=%h st=%h il=%h dl=%h iw=%b dw=%b want 0,0,0,0,0,0,1,1",
               ramREN, ramWEN, ramaddr, ramstore, iload, dload, iwait, dwait);
    end
    iREN = 0; dWEN = 0; #1;
    n_checks++;
    if ({iwait, dwait} !== 2'b00) begin
      n_fail++; $display("FAIL reset_waits got %b want 00", {iwait, dwait});
    end
    @(negedge CLK); nRST = 1;
  endtask

  task automatic test_fetch();
    bit done = 0; exp_t e; int c = 1;
    lat = 2;
    sb.push_back('{1'b0, 32'h2108000A});
    @(negedge CLK); iREN = 1; iaddr = 32'h40;
    while (!done && c < 20) begin
      #1;
      if (c == 2) begin
        n_checks++;
        if ({ramREN, ramWEN, ramaddr, iload, iwait} !== {1'b1, 1'b0, 32'h40, 32'h0, 1'b1}) begin
          n_fail++;
          $display("FAIL fetch_grant got ren=%b wen=%b addr=%h il=%h iw=%b want 1,0,40,0,1",
                   ramREN, ramWEN, ramaddr, iload, iwait);
        end
      end
      if (!iwait) begin
        done = 1; e = sb.pop_front();
        n_checks++;
        if (iload !== e.val) begin n_fail++; $display("FAIL fetch_data got %h want %h", iload, e.val); end
        n_checks++;
        if (c != 4) begin n_fail++; $display("FAIL fetch_latency got cycle %0d want 4", c); end
      end
      @(negedge CLK); c++;
    end
    if (!done) begin n_checks++; n_fail++; $display("FAIL fetch_timeout got no completion want completion"); end
    #1;
    n_checks++;
    if ({ramREN, iwait} !== 2'b01) begin
      n_fail++; $display("FAIL fetch_idle got ren=%b iw=%b want 0,1", ramREN, iwait);
    end
    @(negedge CLK); iREN = 0;
    @(negedge CLK);
  endtask

  task automatic test_conflict();
    exp_t e; int k = 0; bit dbl = 0;
    nRST = 0; iREN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h200; lat = 0;
    for (int i = 0; i < 6; i++)
      sb.push_back((i % 3 == 2) ? '{1'b0, model_rd(32'h44)} : '{1'b1, model_rd(32'h200)});
    @(negedge CLK); nRST = 1;
    for (int c = 0; c < 60 && sb.size() > 0; c++) begin
      #1;
      if (!iwait && !dwait) dbl = 1;
      else if (!iwait || !dwait) begin
        e = sb.pop_front(); k++;
        n_checks++;
        if (!iwait && (e.is_data !== 1'b0 || iload !== e.val)) begin
          n_fail++; $display("FAIL conflict_order #%0d got I/%h want %s/%h", k, iload, e.is_data ? "D" : "I", e.val);
        end else if (!dwait && (e.is_data !== 1'b1 || dload !== e.val)) begin
          n_fail++; $display("FAIL conflict_order #%0d got D/%h want %s/%h", k, dload, e.is_data ? "D" : "I", e.val);
        end
      end
      @(negedge CLK);
    end
    n_checks++;
    if (dbl || sb.size() != 0) begin
      n_fail++; $display("FAIL conflict_complete got double=%0d left=%0d want 0,0", dbl, sb.size());
      sb.delete();
    end
    iREN = 0; dREN = 0;
    @(negedge CLK);
  endtask

  task automatic test_store();
    bit done = 0; int c = 1;
    lat = 1;
    @(negedge CLK); dWEN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF;
    while (!done && c < 20) begin
      #1;
      if (c >= 2) begin
        n_checks++;
        if ({ramREN, ramWEN, ramaddr, ramstore} !== {1'b0, 1'b1, 32'h80, 32'hDEADBEEF}) begin
          n_fail++; $display("FAIL store_drive c%0d got ren=%b wen=%b addr=%h st=%h want 0,1,80,deadbeef",
                             c, ramREN, ramWEN, ramaddr, ramstore);
        end
      end
      if (!dwait) begin
        done = 1;
        n_checks++;
        if (c != 3) begin n_fail++; $display("FAIL store_latency got cycle %0d want 3", c); end
      end
      else @(negedge CLK);
      c++;
    end
    if (!done) begin n_checks++; n_fail++; $display("FAIL store_timeout got no completion want completion"); end
    @(negedge CLK); #1;
    n_checks++;
    if ({dwait, ramWEN} !== 2'b10) begin
      n_fail++; $display("FAIL store_wait_one_cycle got dw=%b wen=%b want 1,0", dwait, ramWEN);
    end
    @(negedge CLK); dWEN = 0; #1;
    n_checks++;
    if ({dwait, ramWEN} !== 2'b00) begin
      n_fail++; $display("FAIL store_abort got dw=%b wen=%b want 0,0", dwait, ramWEN);
    end
    @(negedge CLK); #1;
    n_checks++;
    if (model_rd(32'h80) !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL store_mem got %h want deadbeef", model_rd(32'h80));
    end
  endtask

  task automatic test_error();
    exp_t e;
    lat = 0;
    sb.push_back('{1'b1, model_rd(32'h300)});
    @(negedge CLK); dREN = 1; daddr = 32'h300; force_err = 1;
    @(negedge CLK); #1;
    n_checks++;
    if ({ramREN, dwait, dload} !== {1'b1, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL error_cycle got ren=%b dw=%b dl=%h want 1,1,0", ramREN, dwait, dload);
    end
    @(negedge CLK); force_err = 0; #1;
    n_checks++;
    if ({ramREN, dwait} !== 2'b01) begin
      n_fail++; $display("FAIL error_idle got ren=%b dw=%b want 0,1", ramREN, dwait);
    end
    @(negedge CLK); #1;
    e = sb.pop_front();
    n_checks++;
    if (dwait !== 1'b0 || dload !== e.val) begin
      n_fail++; $display("FAIL error_regrant got dw=%b dl=%h want 0,%h", dwait, dload, e.val);
    end
    @(negedge CLK); dREN = 0;
    @(negedge CLK);
  endtask

  task automatic test_sc();
    bit done, wrote; word_t got; int cyc; exp_t e;
    lat = 0;
`ifdef LLSC_EN
    sb.push_back('{1'b1, model_rd(32'h100)});
    data_xact(0, 1, 32'h100, 32'h0, done, got, wrote, cyc);
    e = sb.pop_front(); n_checks++;
    if (!done || got !== e.val) begin n_fail++; $display("FAIL ll_data got %h want %h", got, e.val); end
    sb.push_back('{1'b1, 32'd1});
    data_xact(1, 1, 32'h100, 32'h1234, done, got, wrote, cyc);
    e = sb.pop_front(); n_checks++;
    if (!done || got !== e.val || !wrote) begin
      n_fail++; $display("FAIL sc_success got dl=%h wrote=%b want %h,1", got, wrote, e.val);
    end
    n_checks++;
    if (model_rd(32'h100) !== 32'h1234) begin n_fail++; $display("FAIL sc_success_mem got %h want 1234", model_rd(32'h100)); end
    data_xact(0, 1, 32'h100, 32'h0, done, got, wrote, cyc);
    data_xact(1, 0, 32'h100, 32'h55, done, got, wrote, cyc);
    sb.push_back('{1'b1, 32'd0});
    data_xact(1, 1, 32'h100, 32'h99, done, got, wrote, cyc);
    e = sb.pop_front(); n_checks++;
    if (!done || got !== e.val || wrote || cyc != 2) begin
      n_fail++; $display("FAIL sc_fail got dl=%h wrote=%b cyc=%0d want %h,0,2", got, wrote, cyc, e.val);
    end
    n_checks++;
    if (model_rd(32'h100) !== 32'h55) begin n_fail++; $display("FAIL sc_fail_mem got %h want 55", model_rd(32'h100)); end
    data_xact(0, 1, 32'h100, 32'h0, done, got, wrote, cyc);
    #2 nRST = 0; #1 nRST = 1;
    data_xact(1, 1, 32'h100, 32'h77, done, got, wrote, cyc);
    n_checks++;
    if (!done || got !== 32'd0 || wrote) begin
      n_fail++; $display("FAIL sc_after_reset got dl=%h wrote=%b want 0,0", got, wrote);
    end
`else
    sb.push_back('{1'b1, model_rd(32'h100)});
    data_xact(1, 1, 32'h100, 32'h77, done, got, wrote, cyc);
    e = sb.pop_front(); n_checks++;
    if (!done || got !== e.val || !wrote) begin
      n_fail++; $display("FAIL sc_plain got dl=%h wrote=%b want %h,1", got, wrote, e.val);
    end
    n_checks++;
    if (model_rd(32'h100) !== 32'h77) begin n_fail++; $display("FAIL sc_plain_mem got %h want 77", model_rd(32'h100)); end
`endif
  endtask

  task automatic test_reset_mid();
    int nd = 0; bit bad = 0; bit first_d = 0; bit seen = 0;
    // Build a full data streak, then reset during the fetch it forces.
    nRST = 0; iREN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h200; lat = 0;
    @(negedge CLK); nRST = 1;
    for (int c = 0; c < 20 && nd < 2; c++) begin
      #1;
      if (!iwait) bad = 1;
      if (!dwait) nd++;
      @(negedge CLK);
    end
    lat = 8;
    @(negedge CLK); #1;
    n_checks++;
    if (bad || nd != 2 || {ramREN, ramaddr} !== {1'b1, 32'h44}) begin
      n_fail++; $display("FAIL streak_limit got early_i=%b nd=%0d ren=%b addr=%h want 0,2,1,44", bad, nd, ramREN, ramaddr);
    end
    #1 nRST = 0; #1;
    n_checks++;
    if (ramREN !== 1'b0) begin n_fail++; $display("FAIL rst_async_iren got %b want 0", ramREN); end
    @(negedge CLK); nRST = 1; lat = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (!dwait || !iwait) begin seen = 1; first_d = !dwait && iwait; end
      @(negedge CLK);
    end
    n_checks++;
    if (!first_d) begin n_fail++; $display("FAIL rst_streak_clear got first=%s want D", seen ? "I" : "none"); end
    iREN = 0; dREN = 0;
    @(negedge CLK);
    dWEN = 1; daddr = 32'h80; dstore = 32'hCAFEF00D; lat = 8;
    @(negedge CLK); #1;
    n_checks++;
    if (ramWEN !== 1'b1) begin n_fail++; $display("FAIL rst_mid_grant_setup got wen=%b want 1", ramWEN); end
    #1 nRST = 0; #1;
    n_checks++;
    if ({ramREN, ramWEN, ramaddr, ramstore, dwait} !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b1}) begin
      n_fail++; $display("FAIL rst_mid_grant got ren=%b wen=%b addr=%h st=%h dw=%b want 0,0,0,0,1",
                         ramREN, ramWEN, ramaddr, ramstore, dwait);
    end
    @(negedge CLK); dWEN = 0; nRST = 1; lat = 0;
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_conflict();
    test_store();
    test_error();
    test_sc();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
